smart_cargo_status_tx: RTL

//  Downstream stage of the SmartCargo datapath. Reports elevator status to the host over UART 8N1.

---
 rtl/smart_cargo_pkg.sv | 30 +++
 rtl/smart_cargo_status_tx_uart_tx_8n1.sv | 63 ++++++
 rtl/smart_cargo_status_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/smart_cargo_pkg.sv
// Shared definitions for the SmartCargo status transmitter: sequencer state codes,
// frame header byte, cargo codes and the byte-packing helpers.
package smart_cargo_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SNAPSHOT  = 4'd1,
    ST_SEND      = 4'd2,
    ST_NEXT      = 4'd3,
    ST_READ_SLOT = 4'd4,
    ST_CAPTURE   = 4'd5,
    ST_DONE      = 4'd6
  } state_t;

  localparam logic [7:0] START_BYTE  = 8'h7E;
  localparam logic [1:0] CARGO_EMPTY = 2'b00;

  function automatic logic [7:0] status_byte(input logic       sentido,
                                             input logic       tem,
                                             input logic [1:0] prox,
                                             input logic [1:0] andar);
    return {2'b00, sentido, tem, prox, andar};
  endfunction

  function automatic logic [7:0] slot_byte(input logic [1:0] tipo,
                                           input logic [1:0] destino);
    return {4'b0000, tipo, destino};
  endfunction

endpackage

// File: rtl/smart_cargo_status_tx_uart_tx_8n1.sv
// UART 8N1 transmitter: one byte per partida pulse, LSB first, BAUD_DIV cycles per bit.
// fim_tx is high during the final cycle of the stop bit.
module uart_tx_8n1 #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados,
  output logic       TX,
  output logic       ocupado_tx,
  output logic       fim_tx
);

  localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    STOP_BIT  = 4'd9;

  logic [CW-1:0] baud_cnt_reg;
  logic [3:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          busy_reg;
  logic          tx_reg;

  // bit_reg: 0 = start, 1..8 = data, 9 = stop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baud_cnt_reg <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      busy_reg     <= 1'b0;
      tx_reg       <= 1'b1;
    end else if (!busy_reg) begin
      if (partida) begin
        busy_reg     <= 1'b1;
        shift_reg    <= dados;
        tx_reg       <= 1'b0;
        baud_cnt_reg <= '0;
        bit_reg      <= '0;
      end
    end else if (baud_cnt_reg == BAUD_LAST) begin
      baud_cnt_reg <= '0;
      if (bit_reg == STOP_BIT) begin
        busy_reg <= 1'b0;
      end else begin
        bit_reg <= bit_reg + 4'd1;
        if (bit_reg < 4'd8) begin
          tx_reg    <= shift_reg[0];
          shift_reg <= {1'b0, shift_reg[7:1]};
        end else begin
          tx_reg <= 1'b1;
        end
      end
    end else begin
      baud_cnt_reg <= baud_cnt_reg + 1'b1;
    end
  end

  assign TX         = tx_reg;
  assign ocupado_tx = busy_reg;
  assign fim_tx     = busy_reg && (bit_reg == STOP_BIT) && (baud_cnt_reg == BAUD_LAST);

endmodule

// File: rtl/smart_cargo_status_tx.sv
// Frame sequencer: snapshots elevator status, walks the contents RAM and sends
// START, status, one byte per slot and an XOR checksum over UART 8N1.
module smart_cargo_status_tx
  import smart_cargo_pkg::*;
#(
  parameter int          BAUD_DIV   = 434,
  parameter int          N_SLOTS    = 4,
  parameter int unsigned PERIOD     = 50_000_000,
  parameter logic [7:0]  START_BYTE = smart_cargo_pkg::START_BYTE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enviar,
  input  logic [1:0] andar_atual,
  input  logic [1:0] prox_parada,
  input  logic       sentido_elevador,
  input  logic       tem_destino,
  output logic [3:0] conteudo_addr,
  input  logic [1:0] conteudo_tipo,
  input  logic [1:0] conteudo_destino,
  output logic       TX,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam logic [4:0]  STATUS_IDX  = 5'd1;
  localparam logic [4:0]  LAST_IDX    = 5'(N_SLOTS + 2);
  localparam logic [25:0] PERIOD_LAST = 26'(PERIOD - 1);

  state_t      state_reg, state_next;
  logic [7:0]  status_reg;
  logic [7:0]  csum_reg;
  logic [4:0]  byte_idx_reg;
  logic [3:0]  addr_reg;
  logic [1:0]  wait_reg;
  logic        pending_reg;
  logic [25:0] timer_reg;

  logic       tick, trigger, direct_byte;
  logic       partida, ocupado_fsm;
  logic [7:0] dados, snap, slot_data;
  logic       tx_busy, fim_tx;

  assign tick        = (PERIOD != 0) && (timer_reg == PERIOD_LAST);
  assign trigger     = enviar || tick;
  assign direct_byte = (byte_idx_reg == STATUS_IDX) || (byte_idx_reg == LAST_IDX);
  assign snap        = status_byte(sentido_elevador, tem_destino, prox_parada, andar_atual);
  assign slot_data   = slot_byte(conteudo_tipo, conteudo_destino);

  uart_tx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clock      (clock),
    .reset      (reset),
    .partida    (partida),
    .dados      (dados),
    .TX         (TX),
    .ocupado_tx (tx_busy),
    .fim_tx     (fim_tx)
  );

  // Header and checksum bytes linger in NEXT so every inter-byte gap matches
  // the three cycles the slot path needs for the RAM read.
  always_comb begin
    state_next  = state_reg;
    partida     = 1'b0;
    dados       = START_BYTE;
    pronto      = 1'b0;
    ocupado_fsm = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        ocupado_fsm = trigger;
        if (trigger) state_next = ST_SNAPSHOT;
      end
      ST_SNAPSHOT: begin
        partida    = 1'b1;
        dados      = START_BYTE;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (fim_tx) state_next = (byte_idx_reg == LAST_IDX) ? ST_DONE : ST_NEXT;
      end
      ST_NEXT: begin
        if (direct_byte) begin
          if (wait_reg == 2'd2) begin
            partida    = 1'b1;
            dados      = (byte_idx_reg == STATUS_IDX) ? status_reg : csum_reg;
            state_next = ST_SEND;
          end
        end else begin
          state_next = ST_READ_SLOT;
        end
      end
      ST_READ_SLOT: state_next = ST_CAPTURE;
      ST_CAPTURE: begin
        partida    = 1'b1;
        dados      = slot_data;
        state_next = ST_SEND;
      end
      ST_DONE: begin
        pronto      = 1'b1;
        ocupado_fsm = pending_reg || trigger;
        state_next  = (pending_reg || trigger) ? ST_SNAPSHOT : ST_IDLE;
      end
      default: begin
        ocupado_fsm = 1'b0;
        state_next  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      status_reg   <= '0;
      csum_reg     <= '0;
      byte_idx_reg <= '0;
      addr_reg     <= '0;
      wait_reg     <= '0;
      pending_reg  <= 1'b0;
      timer_reg    <= '0;
    end else begin
      state_reg <= state_next;

      if (PERIOD == 0 || tick) timer_reg <= '0;
      else                     timer_reg <= timer_reg + 26'd1;

      // DONE either consumes the pending request or has none to consume
      if (state_reg == ST_DONE)                   pending_reg <= 1'b0;
      else if (trigger && state_reg != ST_IDLE)   pending_reg <= 1'b1;

      case (state_reg)
        ST_SNAPSHOT: begin
          status_reg   <= snap;
          csum_reg     <= snap;
          byte_idx_reg <= '0;
          wait_reg     <= '0;
        end
        ST_SEND: begin
          if (fim_tx) begin
            byte_idx_reg <= byte_idx_reg + 5'd1;
            wait_reg     <= '0;
          end
        end
        ST_NEXT: begin
          if (direct_byte) wait_reg <= wait_reg + 2'd1;
          else             addr_reg <= byte_idx_reg[3:0] - 4'd2;
        end
        ST_CAPTURE: csum_reg <= csum_reg ^ slot_data;
        default: ;
      endcase
    end
  end

  assign ocupado       = ocupado_fsm || tx_busy;
  assign conteudo_addr = addr_reg;
  assign db_estado     = state_reg;

endmodule
